// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: byte FIFO, baud strobe and send/done sequencer in front of a UART transmitter.
// Define UART_TX_FEEDER_OVF_EN to add the sticky overflow flag (ovf) and its clear input (ovf_clr).
module uart_tx_feeder #(
    parameter int DEPTH_LOG2 = 4,
    parameter int BAUD_DIV   = 16
) (
    input  logic                ref_clk,
    input  logic                rst,
    input  logic [7:0]          wr_data,
    input  logic                wr_valid,
    output logic                wr_ready,
    output logic [DEPTH_LOG2:0] level,
    output logic                bit_clk,
    output logic                tx_send,
    output logic [0:7]          tx_data,
    input  logic                tx_done,
`ifdef UART_TX_FEEDER_OVF_EN
    output logic                ovf,
    input  logic                ovf_clr,
`endif
    output logic                busy
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int DIV_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(BAUD_DIV - 1);
    localparam logic [DEPTH_LOG2:0] FULL     = (DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GAP
    } state_t;

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   count;
    logic [DIV_W-1:0]      div;
    logic [0:7]            head;
    state_t                state;
    logic                  do_wr;
    logic                  do_pop;

    assign wr_ready = (count != FULL);
    assign do_wr    = wr_valid && wr_ready;
    assign do_pop   = (state == IDLE) && (count != '0);
    assign level    = count;
    assign busy     = (state != IDLE) || (count != '0);

    // NOTE: state registers use non-blocking assignments so every block sees pre-edge values.
    always_ff @(posedge ref_clk) begin
        if (rst) begin
            div     <= '0;
            bit_clk <= 1'b0;
        end else begin
            bit_clk <= (div == DIV_LAST);
            div     <= (div == DIV_LAST) ? '0 : div + 1'b1;
        end
    end

    // NOTE: the storage array is deliberately not reset; a slot is only read after it was written.
    always_ff @(posedge ref_clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // NOTE: every bit of head is assigned on every evaluation, so no latch is inferred.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            head[i] = mem[rd_ptr][i];
        end
    end

    // Pointers wrap naturally at DEPTH_LOG2 bits; count tracks occupancy 0..DEPTH.
    always_ff @(posedge ref_clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_wr, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // GAP holds send low for one cycle so the transmitter can clear done before the next byte.
    always_ff @(posedge ref_clk) begin
        if (rst) begin
            state   <= IDLE;
            tx_send <= 1'b0;
            tx_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (do_pop) begin
                        tx_data <= head;
                        tx_send <= 1'b1;
                        state   <= SEND;
                    end
                end
                SEND: begin
                    if (tx_done) begin
                        tx_send <= 1'b0;
                        state   <= GAP;
                    end
                end
                GAP: begin
                    state <= IDLE;
                end
                default: begin
                    tx_send <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

`ifdef UART_TX_FEEDER_OVF_EN
    always_ff @(posedge ref_clk) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (wr_valid && !wr_ready) begin
            ovf <= 1'b1;
        end else if (ovf_clr) begin
            ovf <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Bench for uart_tx_feeder: queue-based reference model, behavioural serial transmitter, directed and random stimulus.
// Build with UART_TX_FEEDER_OVF_EN defined to also exercise the overflow flag.
module tb_uart_tx_feeder;

    localparam int DEPTH_LOG2 = 2;
    localparam int BAUD_DIV   = 4;
    localparam int DEPTH      = 1 << DEPTH_LOG2;

    logic                ref_clk = 1'b0;
    logic                rst;
    logic [7:0]          wr_data;
    logic                wr_valid;
    logic                wr_ready;
    logic [DEPTH_LOG2:0] level;
    logic                bit_clk;
    logic                tx_send;
    logic [0:7]          tx_data;
    logic                tx_done = 1'b0;
    logic                busy;
`ifdef UART_TX_FEEDER_OVF_EN
    logic                ovf;
    logic                ovf_clr;
`endif

    int total = 0;
    int bad   = 0;

    uart_tx_feeder #(
        .DEPTH_LOG2(DEPTH_LOG2),
        .BAUD_DIV  (BAUD_DIV)
    ) dut (
        .ref_clk (ref_clk),
        .rst     (rst),
        .wr_data (wr_data),
        .wr_valid(wr_valid),
        .wr_ready(wr_ready),
        .level   (level),
        .bit_clk (bit_clk),
        .tx_send (tx_send),
        .tx_data (tx_data),
        .tx_done (tx_done),
`ifdef UART_TX_FEEDER_OVF_EN
        .ovf     (ovf),
        .ovf_clr (ovf_clr),
`endif
        .busy    (busy)
    );

    always #5 ref_clk = ~ref_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] to_byte(input logic [0:7] v);
        logic [7:0] b;
        for (int i = 0; i < 8; i++) b[i] = v[i];
        return b;
    endfunction

    // Reference model: bytes waiting, the byte on offer, and whether we are in the post-done gap.
    logic [7:0] m_q[$];
    logic [7:0] m_exp_tx[$];
    logic [7:0] rx_log[$];
    logic [7:0] m_cur = 8'h00;
    bit         m_sending = 1'b0;
    bit         m_gap = 1'b0;
    bit         m_live = 1'b0;
    bit         m_ovf = 1'b0;
    int         m_cyc = 0;

    always @(posedge ref_clk) begin
        if (rst) begin
            m_q.delete();
            m_exp_tx.delete();
            m_cur     = 8'h00;
            m_sending = 1'b0;
            m_gap     = 1'b0;
            m_ovf     = 1'b0;
            m_cyc     = 0;
            m_live    = 1'b1;
        end else if (m_live) begin
            bit full_before;
            full_before = (m_q.size() == DEPTH);
`ifdef UART_TX_FEEDER_OVF_EN
            if (wr_valid && full_before) m_ovf = 1'b1;
            else if (ovf_clr)            m_ovf = 1'b0;
`endif
            if (m_sending) begin
                if (tx_done) begin
                    m_sending = 1'b0;
                    m_gap     = 1'b1;
                end
            end else if (m_gap) begin
                m_gap = 1'b0;
            end else if (m_q.size() != 0) begin
                m_cur     = m_q.pop_front();
                m_sending = 1'b1;
                m_exp_tx.push_back(m_cur);
            end
            if (wr_valid && !full_before) m_q.push_back(wr_data);
            m_cyc++;
        end
        #1;
        if (m_live) begin
            check("level",    32'(level),           32'(m_q.size()));
            check("wr_ready", 32'(wr_ready),        32'(m_q.size() != DEPTH));
            check("bit_clk",  32'(bit_clk),         32'(m_cyc != 0 && (m_cyc % BAUD_DIV) == 0));
            check("tx_send",  32'(tx_send),         32'(m_sending));
            check("tx_data",  32'(to_byte(tx_data)), 32'(m_cur));
            check("busy",     32'(busy),            32'(m_sending || m_gap || m_q.size() != 0));
`ifdef UART_TX_FEEDER_OVF_EN
            check("ovf",      32'(ovf),             32'(m_ovf));
`endif
        end
    end

    // Behavioural transmitter: start bit, 8 data bits LSB first, stop bit, then done until send drops.
    bit         tx_active = 1'b0;
    bit         tx_fin = 1'b0;
    int         tx_bit = 0;
    logic       line = 1'b1;
    logic [7:0] rx_byte = 8'h00;

    always @(negedge ref_clk) begin
        if (!tx_send) begin
            tx_active = 1'b0;
            tx_fin    = 1'b0;
            line      = 1'b1;
        end else if (!tx_fin) begin
            if (!tx_active) begin
                tx_active = 1'b1;
                tx_bit    = 0;
                line      = 1'b0;
            end else if (bit_clk) begin
                tx_bit++;
                if (tx_bit <= 8) begin
                    line = tx_data[tx_bit-1];
                    rx_byte[tx_bit-1] = line;
                end else if (tx_bit == 9) begin
                    line = 1'b1;
                end else begin
                    tx_active = 1'b0;
                    tx_fin    = 1'b1;
                    rx_log.push_back(rx_byte);
                    if (m_exp_tx.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL serial: got %02h want no byte", rx_byte);
                    end else begin
                        check("serial", 32'(rx_byte), 32'(m_exp_tx.pop_front()));
                    end
                end
            end
        end
        // Stray done pulses while send is low must be ignored by the feeder.
        tx_done = tx_fin | (!tx_send && $urandom_range(0, 7) == 0);
    end

    task automatic wait_send(input logic v, input int budget, input string name);
        for (int i = 0; i < budget && tx_send !== v; i++) @(negedge ref_clk);
        check(name, 32'(tx_send), 32'(v));
    endtask

    task automatic wait_idle(input int budget, input string name);
        for (int i = 0; i < budget && busy !== 1'b0; i++) @(negedge ref_clk);
        check(name, 32'(busy), 32'd0);
    endtask

    task automatic write_burst(input logic [7:0] first, input int n);
        wr_valid = 1'b1;
        for (int i = 0; i < n; i++) begin
            wr_data = first + 8'(i);
            @(negedge ref_clk);
        end
        wr_valid = 1'b0;
    endtask

    initial begin
        logic [7:0] exp_burst [6];
        exp_burst = '{8'hEE, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        rst      = 1'b1;
        wr_valid = 1'b0;
        wr_data  = 8'h00;
`ifdef UART_TX_FEEDER_OVF_EN
        ovf_clr  = 1'b0;
`endif
        repeat (3) @(negedge ref_clk);
        check("rst_wr_ready", 32'(wr_ready), 32'd1);
        check("rst_level",    32'(level),    32'd0);
        check("rst_tx_send",  32'(tx_send),  32'd0);
        check("rst_tx_data",  32'(to_byte(tx_data)), 32'd0);
        check("rst_busy",     32'(busy),     32'd0);
        rst = 1'b0;

        // Idle after reset: strobe on cycles 4 and 8 only.
        repeat (3) @(negedge ref_clk);
        check("bclk_c3", 32'(bit_clk), 32'd0);
        @(negedge ref_clk);
        check("bclk_c4", 32'(bit_clk), 32'd1);
        @(negedge ref_clk);
        check("bclk_c5", 32'(bit_clk), 32'd0);
        repeat (3) @(negedge ref_clk);
        check("bclk_c8", 32'(bit_clk), 32'd1);
        check("idle_send", 32'(tx_send), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);

        // Single byte 0xA5.
        rx_log.delete();
        write_burst(8'hA5, 1);
        check("a5_level1", 32'(level), 32'd1);
        check("a5_send0",  32'(tx_send), 32'd0);
        @(negedge ref_clk);
        check("a5_send1",  32'(tx_send), 32'd1);
        check("a5_data",   32'(to_byte(tx_data)), 32'hA5);
        check("a5_level0", 32'(level), 32'd0);
        wait_send(1'b0, 200, "a5_done");
        check("a5_gap_busy", 32'(busy), 32'd1);
        @(negedge ref_clk);
        check("a5_idle_busy", 32'(busy), 32'd0);
        check("a5_rx_count", 32'(rx_log.size()), 32'd1);
        if (rx_log.size() > 0) check("a5_rx", 32'(rx_log[0]), 32'hA5);

        // Filler byte keeps the FSM busy so 0x01..0x04 fill the FIFO and 0x05 waits.
        rx_log.delete();
        write_burst(8'hEE, 1);
        write_burst(8'h01, 4);
        wr_valid = 1'b1;
        wr_data  = 8'h05;
        check("full_ready", 32'(wr_ready), 32'd0);
        check("full_level", 32'(level), 32'd4);
        for (int i = 0; i < 200 && wr_ready !== 1'b1; i++) @(negedge ref_clk);
        check("pop_ready", 32'(wr_ready), 32'd1);
        check("pop_level", 32'(level), 32'd3);
        @(negedge ref_clk);
        wr_valid = 1'b0;
        check("refill_level", 32'(level), 32'd4);
        wait_idle(600, "burst_drain");
        check("burst_rx_count", 32'(rx_log.size()), 32'd6);
        for (int i = 0; i < 6 && i < rx_log.size(); i++)
            check($sformatf("burst_rx%0d", i), 32'(rx_log[i]), 32'(exp_burst[i]));

        // Reset in the middle of byte 2 of 3.
        rx_log.delete();
        write_burst(8'h11, 1);
        write_burst(8'h22, 1);
        write_burst(8'h33, 1);
        wait_send(1'b0, 200, "b1_done");
        wait_send(1'b1, 20, "b2_start");
        repeat (10) @(negedge ref_clk);
        rst = 1'b1;
        @(negedge ref_clk);
        rst = 1'b0;
        check("mid_rst_send",  32'(tx_send), 32'd0);
        check("mid_rst_level", 32'(level), 32'd0);
        repeat (100) @(negedge ref_clk);
        check("mid_rst_quiet", 32'(tx_send), 32'd0);
        check("mid_rst_rx_count", 32'(rx_log.size()), 32'd1);
        if (rx_log.size() > 0) check("mid_rst_rx0", 32'(rx_log[0]), 32'h11);
        write_burst(8'h5A, 1);
        wait_idle(200, "post_rst_drain");
        check("post_rst_rx_count", 32'(rx_log.size()), 32'd2);
        if (rx_log.size() > 1) check("post_rst_rx", 32'(rx_log[1]), 32'h5A);

        // Random traffic with occasional resets; the model checks every cycle.
        for (int c = 0; c < 3000; c++) begin
            wr_valid = ($urandom_range(0, 2) != 0);
            wr_data  = 8'($urandom);
            rst      = ($urandom_range(0, 599) == 0);
`ifdef UART_TX_FEEDER_OVF_EN
            ovf_clr  = ($urandom_range(0, 15) == 0);
`endif
            @(negedge ref_clk);
        end
        wr_valid = 1'b0;
        rst      = 1'b0;
`ifdef UART_TX_FEEDER_OVF_EN
        ovf_clr  = 1'b0;
`endif
        wait_idle(1000, "rand_drain");

`ifdef UART_TX_FEEDER_OVF_EN
        ovf_clr = 1'b1;
        @(negedge ref_clk);
        ovf_clr = 1'b0;
        check("ovf_start_clr", 32'(ovf), 32'd0);
        write_burst(8'h40, 6);
        check("ovf_set", 32'(ovf), 32'd1);
        repeat (5) @(negedge ref_clk);
        check("ovf_sticky", 32'(ovf), 32'd1);
        ovf_clr = 1'b1;
        @(negedge ref_clk);
        ovf_clr = 1'b0;
        check("ovf_cleared", 32'(ovf), 32'd0);
        check("ovf_still_full", 32'(wr_ready), 32'd0);
        wr_valid = 1'b1;
        ovf_clr  = 1'b1;
        @(negedge ref_clk);
        wr_valid = 1'b0;
        ovf_clr  = 1'b0;
        check("ovf_set_wins", 32'(ovf), 32'd1);
        wait_idle(600, "ovf_drain");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
